// File: rtl/fibonacci_pkg.sv
// fibonacci_pkg
// Shared types and constants for the Fibonacci / Lucas sequence calculator:
//   fibo_state_e : controller states (IDLE, COMPUTE, DONE)
//   fibo_mode_e  : sequence select (MODE_FIB = seeds 0,1; MODE_LUCAS = seeds 2,1)
//   fibo_dbg_t   : debug view of the controller (state + latched mode)
//   *_SEED*      : sequence seed constants
package fibonacci_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } fibo_state_e;

    typedef enum logic {
        MODE_FIB   = 1'b0,
        MODE_LUCAS = 1'b1
    } fibo_mode_e;

    typedef struct packed {
        fibo_state_e state;
        fibo_mode_e  mode;
    } fibo_dbg_t;

    localparam int unsigned FIB_SEED0   = 0;
    localparam int unsigned FIB_SEED1   = 1;
    localparam int unsigned LUCAS_SEED0 = 2;
    localparam int unsigned LUCAS_SEED1 = 1;

endpackage

// File: rtl/fibonacci_calculator_param_add.sv
// fibo_add_ovf
// W-bit adder with a sticky overflow flag that travels alongside each operand.
// Optional build macro: FIBO_SATURATE_EN -- when defined, any overflowed sum
// is replaced by all-ones instead of wrapping modulo 2^W.
// Ports:
//   a_i, b_i         : operands
//   a_ovf_i, b_ovf_i : overflow flags already attached to the operands
//   sum_o            : a_i + b_i (wrapped, or saturated when enabled)
//   ovf_o            : carry-out of this add OR either operand flag
module fibo_add_ovf #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         a_ovf_i,
    input  logic         b_ovf_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a_i} + {1'b0, b_i};
        // Overflow is sticky: once any term in the chain overflowed, every
        // later term built from it is also wrong.
        ovf_o    = full_sum[W] | a_ovf_i | b_ovf_i;
`ifdef FIBO_SATURATE_EN
        sum_o    = ovf_o ? {W{1'b1}} : full_sum[W-1:0];
`else
        sum_o    = full_sum[W-1:0];
`endif
    end

endmodule

// File: rtl/fibonacci_calculator_param.sv
// fibonacci_calculator_param
// Iterative Fibonacci / Lucas calculator. A start request latches the index n
// and the mode, then one recurrence step (a <= b, b <= a + b) is taken per
// cycle until the counter reaches n; the result is a, so latency from the
// sampling edge to done is n+1 cycles.
// Optional build macro: FIBO_SATURATE_EN (saturate overflowed sums to
// all-ones; otherwise sums wrap). Overflow is reported in both builds.
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   input_s    : sequence index n (IN_W bits)
//   mode       : 0 = Fibonacci, 1 = Lucas
//   begin_fibo : start request
//   fibo_out   : result of the last completed computation
//   done       : result valid
//   busy       : high exactly while computing
//   overflow   : result exceeded OUT_W bits
//   dbg        : controller state and latched mode, for observation only
// Handshake: begin_fibo is sampled only in IDLE and starts one computation.
// done rises with the result and stays high while begin_fibo is held; the
// block returns to IDLE only after begin_fibo is seen low, so a held request
// can never start a second computation.
module fibonacci_calculator_param
    import fibonacci_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  input_s,
    input  logic             mode,
    input  logic             begin_fibo,
    output logic [OUT_W-1:0] fibo_out,
    output logic             done,
    output logic             busy,
    output logic             overflow,
    output fibo_dbg_t        dbg
);

    fibo_state_e      state_q, state_d;
    fibo_mode_e       mode_q, mode_d;
    logic [IN_W-1:0]  n_q, n_d;
    logic [IN_W-1:0]  count_q, count_d;
    logic [OUT_W-1:0] a_q, a_d;
    logic [OUT_W-1:0] b_q, b_d;
    logic             a_ovf_q, a_ovf_d;
    logic             b_ovf_q, b_ovf_d;
    logic [OUT_W-1:0] fibo_out_q, fibo_out_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;

    logic [OUT_W-1:0] sum;
    logic             sum_ovf;

    fibo_add_ovf #(
        .W (OUT_W)
    ) u_add (
        .a_i     (a_q),
        .b_i     (b_q),
        .a_ovf_i (a_ovf_q),
        .b_ovf_i (b_ovf_q),
        .sum_o   (sum),
        .ovf_o   (sum_ovf)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        n_d        = n_q;
        count_d    = count_q;
        a_d        = a_q;
        b_d        = b_q;
        a_ovf_d    = a_ovf_q;
        b_ovf_d    = b_ovf_q;
        fibo_out_d = fibo_out_q;
        done_d     = done_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (begin_fibo) begin
                    n_d     = input_s;
                    mode_d  = fibo_mode_e'(mode);
                    a_d     = mode ? OUT_W'(LUCAS_SEED0) : OUT_W'(FIB_SEED0);
                    b_d     = mode ? OUT_W'(LUCAS_SEED1) : OUT_W'(FIB_SEED1);
                    a_ovf_d = 1'b0;
                    b_ovf_d = 1'b0;
                    count_d = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (count_q < n_q) begin
                    a_d     = b_q;
                    a_ovf_d = b_ovf_q;
                    b_d     = sum;
                    b_ovf_d = sum_ovf;
                    count_d = count_q + IN_W'(1);
                end else begin
                    // Only the flag riding with a matters; overflow that
                    // exists solely in b is one term beyond the result.
                    fibo_out_d = a_q;
                    overflow_d = a_ovf_q;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (!begin_fibo) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
        endcase

        busy_d = (state_d == COMPUTE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_FIB;
            n_q        <= '0;
            count_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            a_ovf_q    <= 1'b0;
            b_ovf_q    <= 1'b0;
            fibo_out_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            n_q        <= n_d;
            count_q    <= count_d;
            a_q        <= a_d;
            b_q        <= b_d;
            a_ovf_q    <= a_ovf_d;
            b_ovf_q    <= b_ovf_d;
            fibo_out_q <= fibo_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign fibo_out  = fibo_out_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign dbg.state = state_q;
    assign dbg.mode  = mode_q;

endmodule

// File: tb/tb_fibonacci_calculator_param.sv
module tb_fibonacci_calculator_param;
    import fibonacci_pkg::*;

    localparam int IN_W  = 5;
    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [IN_W-1:0]  input_s = '0;
    logic             mode = 1'b0;
    logic             begin_fibo = 1'b0;
    logic [OUT_W-1:0] fibo_out;
    logic             done;
    logic             busy;
    logic             overflow;
    fibo_dbg_t        dbg;

    // {overflow, value}
    logic [OUT_W:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    fibonacci_calculator_param #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .input_s    (input_s),
        .mode       (mode),
        .begin_fibo (begin_fibo),
        .fibo_out   (fibo_out),
        .done       (done),
        .busy       (busy),
        .overflow   (overflow),
        .dbg        (dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: exact integer sequence, then reduce to OUT_W bits.
    function automatic logic [OUT_W:0] model(input logic m, input int n);
        longint a, b, t;
        a = m ? 64'd2 : 64'd0;
        b = 64'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        if (a > 64'd65535) begin
`ifdef FIBO_SATURATE_EN
            return {1'b1, {OUT_W{1'b1}}};
`else
            return {1'b1, OUT_W'(a)};
`endif
        end
        return {1'b0, OUT_W'(a)};
    endfunction

    // ---------------- driver tasks ----------------
    // Drives a request and pushes its expectation; returns #1 after the
    // sampling edge with begin_fibo still high.
    task automatic start_calc(input logic m, input int n, input logic [OUT_W:0] exp_v);
        @(negedge clk);
        mode       = m;
        input_s    = IN_W'(n);
        begin_fibo = 1'b1;
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
    endtask

    // Waits for done; begin_fibo is high for 'hold' sampling edges in total.
    // At cycle change_at the index is replaced by new_n and mode flipped.
    task automatic wait_done(input int hold, input int change_at, input int new_n,
                             output int cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b0;
        if (hold <= 1) begin_fibo = 1'b0;
        while (done !== 1'b1) begin
            if (cycles >= 100) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (cycles >= hold - 1) begin_fibo = 1'b0;
            if (cycles == change_at) begin
                input_s = IN_W'(new_n);
                mode    = ~mode;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n    = 1'b0;
        begin_fibo = 1'b0;
        #1;
        n_checks++;
        if ({fibo_out, done, busy, overflow} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got out=%0d done=%b busy=%b ovf=%b, expected all 0",
                     fibo_out, done, busy, overflow);
        end
        n_checks++;
        if (dbg.state !== IDLE) begin
            n_errors++;
            $display("FAIL reset_state: got %0d expected %0d", dbg.state, IDLE);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    // Directed table: begin_fibo held 2 cycles for every entry.
    task automatic test_results();
        logic        t_mode[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int          t_n[8]    = '{5, 9, 12, 0, 5, 0, 24, 25};
        logic [OUT_W:0] t_exp[8];
        logic [OUT_W:0] e;
        int          cyc;
        bit          to;
        t_exp[0] = {1'b0, 16'd5};
        t_exp[1] = {1'b0, 16'd34};
        t_exp[2] = {1'b0, 16'd144};
        t_exp[3] = {1'b0, 16'd2};
        t_exp[4] = {1'b0, 16'd11};
        t_exp[5] = {1'b0, 16'd0};
        t_exp[6] = {1'b0, 16'd46368};
`ifdef FIBO_SATURATE_EN
        t_exp[7] = {1'b1, 16'd65535};
`else
        t_exp[7] = {1'b1, 16'd9489};
`endif
        for (int i = 0; i < 8; i++) begin
            start_calc(t_mode[i], t_n[i], t_exp[i]);
            n_checks++;
            if (busy !== 1'b1) begin
                n_errors++;
                $display("FAIL busy_start[%0d]: got %b expected 1", i, busy);
            end
            wait_done(2, -1, 0, cyc, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to) begin
                n_errors++;
                $display("FAIL done_timeout[%0d]: done not seen within 100 cycles", i);
            end
            n_checks++;
            if (cyc !== t_n[i] + 1) begin
                n_errors++;
                $display("FAIL latency[%0d]: got %0d expected %0d", i, cyc, t_n[i] + 1);
            end
            n_checks++;
            if ({overflow, fibo_out} !== e) begin
                n_errors++;
                $display("FAIL result[%0d]: got ovf=%b out=%0d expected ovf=%b out=%0d",
                         i, overflow, fibo_out, e[OUT_W], e[OUT_W-1:0]);
            end
            n_checks++;
            if (busy !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_done[%0d]: got %b expected 0", i, busy);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (done !== 1'b0 || {overflow, fibo_out} !== e) begin
                n_errors++;
                $display("FAIL retain[%0d]: got done=%b ovf=%b out=%0d expected 0 %b %0d",
                         i, done, overflow, fibo_out, e[OUT_W], e[OUT_W-1:0]);
            end
        end
    endtask

    task automatic test_held_begin();
        logic [OUT_W:0] e;
        int cyc;
        bit to;
        start_calc(1'b0, 5, {1'b0, 16'd5});
        wait_done(1000, -1, 0, cyc, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || {overflow, fibo_out} !== e) begin
            n_errors++;
            $display("FAIL held_result: got ovf=%b out=%0d expected ovf=%b out=%0d",
                     overflow, fibo_out, e[OUT_W], e[OUT_W-1:0]);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (done !== 1'b1 || busy !== 1'b0 || fibo_out !== e[OUT_W-1:0]) begin
                n_errors++;
                $display("FAIL held_stay[%0d]: got done=%b busy=%b out=%0d expected 1 0 %0d",
                         k, done, busy, fibo_out, e[OUT_W-1:0]);
            end
        end
        begin_fibo = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || fibo_out !== e[OUT_W-1:0] || dbg.state !== IDLE) begin
            n_errors++;
            $display("FAIL held_release: got done=%b out=%0d state=%0d expected 0 %0d %0d",
                     done, fibo_out, dbg.state, e[OUT_W-1:0], IDLE);
        end
    endtask

    task automatic test_input_change();
        logic [OUT_W:0] e;
        int cyc;
        bit to;
        start_calc(1'b0, 12, {1'b0, 16'd144});
        wait_done(1, 2, 3, cyc, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || cyc !== 13 || {overflow, fibo_out} !== e) begin
            n_errors++;
            $display("FAIL latched_inputs: got out=%0d ovf=%b cycles=%0d expected 144 0 13",
                     fibo_out, overflow, cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        bit saw_busy = 1'b0;
        start_calc(1'b0, 12, {1'b0, 16'd144});
        begin_fibo = 1'b0;
        void'(exp_q.pop_front());  // aborted: no result will come
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({fibo_out, done, busy, overflow} !== '0 || dbg.state !== IDLE) begin
            n_errors++;
            $display("FAIL mid_reset: got out=%0d done=%b busy=%b ovf=%b state=%0d expected all 0",
                     fibo_out, done, busy, overflow, dbg.state);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        n_checks++;
        if (saw_done || saw_busy) begin
            n_errors++;
            $display("FAIL no_restart: got done_seen=%b busy_seen=%b expected 0 0",
                     saw_done, saw_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [OUT_W:0] e;
        logic m;
        int n, cyc;
        bit to;
        for (int i = 0; i < 8; i++) begin
            m = 1'($urandom_range(0, 1));
            n = int'($urandom_range(0, 31));
            start_calc(m, n, model(m, n));
            wait_done(1, -1, 0, cyc, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || cyc !== n + 1 || {overflow, fibo_out} !== e) begin
                n_errors++;
                $display("FAIL b2b[%0d] mode=%b n=%0d: got out=%0d ovf=%b cycles=%0d expected %0d %b %0d",
                         i, m, n, fibo_out, overflow, cyc, e[OUT_W-1:0], e[OUT_W], n + 1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_results();
        test_held_begin();
        test_input_change();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
